// File: rtl/imm_decode_pipe_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// imm_decode_pipe_if : instruction-in / immediate-out handshake bundle
// Rev 1.0
// ----------------------------------------------------------------------------
interface imm_decode_pipe_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_ins;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_imm;
   logic [2:0]      out_fmt;
   logic            out_illegal;

   modport master (
      output in_valid, in_ins, out_ready,
      input  in_ready, out_valid, out_imm, out_fmt, out_illegal
   );

   modport slave (
      input  in_valid, in_ins, out_ready,
      output in_ready, out_valid, out_imm, out_fmt, out_illegal
   );
endinterface
`default_nettype wire

// File: rtl/imm_decode_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// imm_decode_pipe : RV immediate generator feeding a DEPTH-entry output FIFO
// Rev 1.0
// ----------------------------------------------------------------------------
module imm_decode_pipe #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2
) (
   input  wire logic          clk,
   input  wire logic          rst,
   input  wire logic          flush,
   imm_decode_pipe_if.slave   bus
);
   localparam int c_CW = $clog2(DEPTH + 1);
   localparam int c_PW = $clog2(DEPTH);

   localparam logic [2:0] c_FMT_NONE = 3'd0;
   localparam logic [2:0] c_FMT_I    = 3'd1;
   localparam logic [2:0] c_FMT_S    = 3'd2;
   localparam logic [2:0] c_FMT_B    = 3'd3;
   localparam logic [2:0] c_FMT_U    = 3'd4;
   localparam logic [2:0] c_FMT_J    = 3'd5;
   localparam logic [2:0] c_FMT_CSR  = 3'd6;

   logic [31:0]     w_ins;
   logic [31:0]     w_imm32;
   logic [XLEN-1:0] w_imm;
   logic [2:0]      w_fmt;
   logic            w_ill;
   logic            w_push;
   logic            w_pop;
   logic            w_valid;

   logic [c_CW-1:0] r_count;
   logic [c_PW-1:0] r_wr_ptr;
   logic [c_PW-1:0] r_rd_ptr;
   logic [XLEN-1:0] r_mem_imm [DEPTH];
   logic [2:0]      r_mem_fmt [DEPTH];
   logic            r_mem_ill [DEPTH];

   assign w_ins = bus.in_ins;

   always_comb begin
      w_fmt   = c_FMT_NONE;
      w_imm32 = '0;
      w_ill   = 1'b0;
      if (w_ins[1:0] != 2'b11) begin
         w_ill = 1'b1;
      end else begin
         case (w_ins[6:0])
            7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111: begin
               w_fmt   = c_FMT_I;
               w_imm32 = {{20{w_ins[31]}}, w_ins[31:20]};
            end
            7'b0100011: begin
               w_fmt   = c_FMT_S;
               w_imm32 = {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
            end
            7'b1100011: begin
               w_fmt   = c_FMT_B;
               w_imm32 = {{20{w_ins[31]}}, w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
               w_fmt   = c_FMT_U;
               w_imm32 = {w_ins[31:12], 12'h000};
            end
            7'b1101111: begin
               w_fmt   = c_FMT_J;
               w_imm32 = {{12{w_ins[31]}}, w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0};
            end
            7'b1110011: begin
               // SYSTEM opcode: funct3[2] selects the immediate CSR forms
               if (w_ins[14]) begin
                  w_fmt   = c_FMT_CSR;
                  w_imm32 = {27'd0, w_ins[19:15]};
               end else begin
                  w_fmt   = c_FMT_I;
                  w_imm32 = {{20{w_ins[31]}}, w_ins[31:20]};
               end
            end
            default: begin
               w_fmt   = c_FMT_NONE;
               w_imm32 = '0;
            end
         endcase
      end
   end

   // All 32-bit immediates are already sign-correct at bit 31 (CSR has bit 31 = 0)
   generate
      if (XLEN == 64) begin : g_xlen64
         assign w_imm = {{32{w_imm32[31]}}, w_imm32};
      end else begin : g_xlen32
         assign w_imm = w_imm32;
      end
   endgenerate

   assign w_valid      = (r_count != '0);
   assign bus.in_ready = !rst && (r_count < c_CW'(DEPTH));
   assign w_push       = bus.in_valid && bus.in_ready;
   assign w_pop        = w_valid && bus.out_ready;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_count  <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= (r_wr_ptr == c_PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= (r_rd_ptr == c_PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: reads are masked whenever the FIFO is empty
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_imm[r_wr_ptr] <= w_imm;
         r_mem_fmt[r_wr_ptr] <= w_fmt;
         r_mem_ill[r_wr_ptr] <= w_ill;
      end
   end

   assign bus.out_valid   = w_valid;
   assign bus.out_imm     = w_valid ? r_mem_imm[r_rd_ptr] : '0;
   assign bus.out_fmt     = w_valid ? r_mem_fmt[r_rd_ptr] : c_FMT_NONE;
   assign bus.out_illegal = w_valid ? r_mem_ill[r_rd_ptr] : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_imm_decode_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_imm_decode_pipe : vector table plus FIFO scoreboard for XLEN=64 and XLEN=32
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_imm_decode_pipe;
   localparam int DEPTH = 2;
   localparam int NV    = 18;

   typedef struct {
      logic [31:0] ins;
      logic [2:0]  fmt;
      logic        ill;
      logic [63:0] imm;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   logic flush;
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;
   int   t0;

   vec_t vecs [NV];
   vec_t cur;
   vec_t h;
   vec_t q [$];
   bit   exp_v;
   bit   exp_r;

   imm_decode_pipe_if #(.XLEN(64)) b64 ();
   imm_decode_pipe_if #(.XLEN(32)) b32 ();

   assign b32.in_valid  = b64.in_valid;
   assign b32.in_ins    = b64.in_ins;
   assign b32.out_ready = b64.out_ready;

   imm_decode_pipe #(.XLEN(64), .DEPTH(DEPTH)) u_dut64 (
      .clk(clk), .rst(rst), .flush(flush), .bus(b64)
   );
   imm_decode_pipe #(.XLEN(32), .DEPTH(DEPTH)) u_dut32 (
      .clk(clk), .rst(rst), .flush(flush), .bus(b32)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference FIFO: expectations enter on an accepted push, leave on a pop
   always @(negedge clk) begin
      exp_v = (q.size() != 0);
      exp_r = !rst && (q.size() < DEPTH);
      chk("out_valid64", 64'(b64.out_valid), 64'(exp_v));
      chk("out_valid32", 64'(b32.out_valid), 64'(exp_v));
      chk("in_ready64", 64'(b64.in_ready), 64'(exp_r));
      chk("in_ready32", 64'(b32.in_ready), 64'(exp_r));
      if (exp_v) begin
         h = q[0];
         chk("imm64", b64.out_imm, h.imm);
         chk("imm32", 64'(b32.out_imm), 64'(h.imm[31:0]));
         chk("fmt64", 64'(b64.out_fmt), 64'(h.fmt));
         chk("fmt32", 64'(b32.out_fmt), 64'(h.fmt));
         chk("ill64", 64'(b64.out_illegal), 64'(h.ill));
         chk("ill32", 64'(b32.out_illegal), 64'(h.ill));
      end else begin
         chk("idle_imm64", b64.out_imm, 64'd0);
         chk("idle_imm32", 64'(b32.out_imm), 64'd0);
         chk("idle_fmt", 64'(b64.out_fmt), 64'd0);
         chk("idle_ill", 64'(b64.out_illegal), 64'd0);
      end
      if (rst || flush) begin
         q.delete();
      end else begin
         if (exp_v && b64.out_ready) void'(q.pop_front());
         if (b64.in_valid && exp_r) q.push_back(cur);
      end
   end

   task automatic wait_accept();
      int n = 0;
      @(negedge clk);
      while (!b64.in_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!b64.in_ready) begin
         n_vec++;
         n_err++;
         $display("FAIL accept_timeout: got in_ready=0 expected 1 within 40 cycles");
      end
      @(posedge clk);
      #1 b64.in_valid = 1'b0;
   endtask

   task automatic offer(input vec_t v);
      cur          = v;
      b64.in_ins   = v.ins;
      b64.in_valid = 1'b1;
   endtask

   task automatic send(input vec_t v);
      offer(v);
      wait_accept();
   endtask

   task automatic idle(input int n);
      b64.in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (20000) @(posedge clk);
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{32'hFFF00093, 3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
      vecs[1]  = '{32'h800000B7, 3'd4, 1'b0, 64'hFFFF_FFFF_8000_0000};
      vecs[2]  = '{32'hFE000EE3, 3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC};
      vecs[3]  = '{32'h0007D073, 3'd6, 1'b0, 64'h0000_0000_0000_000F};
      vecs[4]  = '{32'h00000000, 3'd0, 1'b1, 64'h0};
      vecs[5]  = '{32'h30200073, 3'd1, 1'b0, 64'h0000_0000_0000_0302};
      vecs[6]  = '{32'h0020A423, 3'd2, 1'b0, 64'h0000_0000_0000_0008};
      vecs[7]  = '{32'hFE112E23, 3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC};
      vecs[8]  = '{32'h0080006F, 3'd5, 1'b0, 64'h0000_0000_0000_0008};
      vecs[9]  = '{32'hFFDFF0EF, 3'd5, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC};
      vecs[10] = '{32'h00001517, 3'd4, 1'b0, 64'h0000_0000_0000_1000};
      vecs[11] = '{32'h0040A083, 3'd1, 1'b0, 64'h0000_0000_0000_0004};
      vecs[12] = '{32'h8000001B, 3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_F800};
      vecs[13] = '{32'h7FF08067, 3'd1, 1'b0, 64'h0000_0000_0000_07FF};
      vecs[14] = '{32'h002081B3, 3'd0, 1'b0, 64'h0};
      vecs[15] = '{32'hFFF00091, 3'd0, 1'b1, 64'h0};
      vecs[16] = '{32'h000FC073, 3'd6, 1'b0, 64'h0000_0000_0000_001F};
      vecs[17] = '{32'h00208463, 3'd3, 1'b0, 64'h0000_0000_0000_0008};

      rst = 1'b1;
      flush = 1'b0;
      b64.in_valid = 1'b0;
      b64.in_ins = '0;
      b64.out_ready = 1'b0;
      cur = vecs[0];
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", 64'(b64.in_ready), 64'd1);

      // Full table streamed with the consumer always ready: one result per cycle
      @(posedge clk);
      #1 b64.out_ready = 1'b1;
      t0 = cyc;
      for (int i = 0; i < NV; i++) send(vecs[i]);
      chk("stream_rate", 64'(cyc - t0), 64'(NV));
      idle(4);

      // Backpressure: two fill the buffer, the third waits until a slot is free
      b64.out_ready = 1'b0;
      send(vecs[0]);
      send(vecs[1]);
      offer(vecs[2]);
      @(negedge clk);
      chk("full_ready", 64'(b64.in_ready), 64'd0);
      @(posedge clk);
      #1 b64.out_ready = 1'b1;
      @(negedge clk);
      chk("pop_no_same_cycle_slot", 64'(b64.in_ready), 64'd0);
      wait_accept();
      idle(4);

      // Flush with a full buffer and a pending offer
      b64.out_ready = 1'b0;
      send(vecs[3]);
      send(vecs[5]);
      offer(vecs[6]);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      b64.in_valid = 1'b0;
      @(negedge clk);
      chk("flush_full_valid", 64'(b64.out_valid), 64'd0);

      // Flush beats a push that would otherwise have landed
      send(vecs[7]);
      offer(vecs[8]);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      b64.in_valid = 1'b0;
      @(negedge clk);
      chk("flush_push_valid", 64'(b64.out_valid), 64'd0);
      @(posedge clk);
      #1 b64.out_ready = 1'b1;
      idle(3);

      // Reset mid-operation with one entry buffered
      b64.out_ready = 1'b0;
      send(vecs[9]);
      rst = 1'b1;
      @(negedge clk);
      chk("ready_in_reset", 64'(b64.in_ready), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("valid_after_reset", 64'(b64.out_valid), 64'd0);
      chk("ready_first_cycle", 64'(b64.in_ready), 64'd1);
      @(posedge clk);
      #1 b64.out_ready = 1'b1;
      t0 = cyc;
      for (int i = NV - 1; i >= 0; i--) send(vecs[i]);
      chk("stream_rate_after_reset", 64'(cyc - t0), 64'(NV));
      idle(5);
      chk("scoreboard_drained", 64'(q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire
